// File: rtl/serv_csr_sched_pkg.sv
// Shared CSR storage select/source codes used by the CSR sequencer and its bench.
package serv_params;

    localparam logic [2:0] CSR_SEL_MSCRATCH = 3'd0;
    localparam logic [2:0] CSR_SEL_MTVEC    = 3'd1;
    localparam logic [2:0] CSR_SEL_MEPC     = 3'd2;
    localparam logic [2:0] CSR_SEL_MCAUSE   = 3'd3;
    localparam logic [2:0] CSR_SEL_MTVAL    = 3'd4;

    localparam logic [1:0] CSR_SOURCE_CSR = 2'd0;
    localparam logic [1:0] CSR_SOURCE_EXT = 2'd1;
    localparam logic [1:0] CSR_SOURCE_SET = 2'd2;
    localparam logic [1:0] CSR_SOURCE_CLR = 2'd3;

endpackage

// File: rtl/serv_csr_sched_bit_counter.sv
// W-cycle pass counter: clears on start, advances while running, flags the last bit.
module serv_bit_counter #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_run,
    output logic o_last
);

    logic [CW-1:0] cnt_r;
    logic          at_end_s;

    assign at_end_s = (cnt_r == CW'(W - 1));
    assign o_last   = i_run && at_end_s;

    // Bit position within the current pass; wraps so every pass starts at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_start) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_run) begin
            if (at_end_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/serv_csr_sched.sv
// CSR/trap sequencer in front of the bit-serial CSR storage.
// Optional mret sequencing is enabled by defining SERV_CSR_SCHED_MRET_EN.
module serv_csr_sched
    import serv_params::*;
#(
    parameter int W = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_csr_req,
    input  logic [2:0] i_csr_sel,
    input  logic [1:0] i_csr_source,
    input  logic       i_trap_req,
    input  logic [3:0] i_mcause,
`ifdef SERV_CSR_SCHED_MRET_EN
    input  logic       i_mret_req,
    output logic       o_mret_ack,
`endif
    output logic       o_csr_ack,
    output logic       o_trap_ack,
    output logic       o_vec_valid,
    output logic       o_busy,
    output logic       o_en,
    output logic [2:0] o_sel,
    output logic [1:0] o_source,
    output logic       o_trap,
    output logic [3:0] o_mcause
);

`ifdef SERV_CSR_SCHED_MRET_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CSR_RUN   = 3'd1,
        ST_TRAP_SAVE = 3'd2,
        ST_TRAP_VEC  = 3'd3,
        ST_DONE      = 3'd4,
        ST_MRET_RUN  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CSR_RUN   = 3'd1,
        ST_TRAP_SAVE = 3'd2,
        ST_TRAP_VEC  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;
`endif

    state_t     state_r, state_next_s;
    logic       pend_r, pend_next_s;
    logic [3:0] mcause_next_s;
    logic       cnt_start_s, cnt_run_s, cnt_last_s;
    logic       en_s, trap_s, vec_s, csr_ack_s, trap_ack_s, mret_ack_s;
    logic [2:0] sel_s;
    logic [1:0] source_s;

    serv_bit_counter #(.W(W)) u_bit_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (cnt_start_s),
        .i_run   (cnt_run_s),
        .o_last  (cnt_last_s)
    );

    // Counter control: run during any shifting pass, clear between jobs.
    always_comb begin
        cnt_start_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        cnt_run_s   = (state_r == ST_CSR_RUN) || (state_r == ST_TRAP_SAVE)
`ifdef SERV_CSR_SCHED_MRET_EN
                   || (state_r == ST_MRET_RUN)
`endif
                   || (state_r == ST_TRAP_VEC);
    end

    // Next state, pending-trap bookkeeping and cause capture.
    always_comb begin
        state_next_s  = state_r;
        pend_next_s   = pend_r;
        mcause_next_s = o_mcause;
        case (state_r)
            ST_IDLE: begin
                if (pend_r || i_trap_req) begin
                    state_next_s = ST_TRAP_SAVE;
                    pend_next_s  = 1'b0;
                    if (i_trap_req) begin
                        mcause_next_s = i_mcause;
                    end else begin
                        mcause_next_s = o_mcause;
                    end
`ifdef SERV_CSR_SCHED_MRET_EN
                end else if (i_mret_req) begin
                    state_next_s = ST_MRET_RUN;
`endif
                end else if (i_csr_req) begin
                    state_next_s = ST_CSR_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
`ifdef SERV_CSR_SCHED_MRET_EN
            ST_MRET_RUN,
`endif
            ST_CSR_RUN, ST_DONE: begin
                // A trap arriving here waits for the current job to finish.
                if (i_trap_req) begin
                    pend_next_s   = 1'b1;
                    mcause_next_s = i_mcause;
                end else begin
                    pend_next_s   = pend_r;
                    mcause_next_s = o_mcause;
                end
                if (state_r == ST_DONE) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_TRAP_SAVE: begin
                if (cnt_last_s) begin
                    state_next_s = ST_TRAP_VEC;
                end else begin
                    state_next_s = ST_TRAP_SAVE;
                end
            end
            ST_TRAP_VEC: begin
                if (cnt_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_TRAP_VEC;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Storage controls decoded from the upcoming state so they register cleanly.
    always_comb begin
        en_s     = 1'b0;
        sel_s    = CSR_SEL_MSCRATCH;
        source_s = CSR_SOURCE_CSR;
        trap_s   = 1'b0;
        vec_s    = 1'b0;
        case (state_next_s)
            ST_CSR_RUN: begin
                en_s = 1'b1;
                if (state_r == ST_IDLE) begin
                    sel_s    = i_csr_sel;
                    source_s = i_csr_source;
                end else begin
                    sel_s    = o_sel;
                    source_s = o_source;
                end
            end
            ST_TRAP_SAVE: begin
                en_s   = 1'b1;
                trap_s = 1'b1;
                sel_s  = CSR_SEL_MEPC;
            end
            ST_TRAP_VEC: begin
                en_s  = 1'b1;
                vec_s = 1'b1;
                sel_s = CSR_SEL_MTVEC;
            end
`ifdef SERV_CSR_SCHED_MRET_EN
            ST_MRET_RUN: begin
                en_s  = 1'b1;
                vec_s = 1'b1;
                sel_s = CSR_SEL_MEPC;
            end
`endif
            default: begin
                en_s = 1'b0;
            end
        endcase
        csr_ack_s  = (state_r == ST_CSR_RUN)  && (state_next_s == ST_DONE);
        trap_ack_s = (state_r == ST_TRAP_VEC) && (state_next_s == ST_DONE);
`ifdef SERV_CSR_SCHED_MRET_EN
        mret_ack_s = (state_r == ST_MRET_RUN) && (state_next_s == ST_DONE);
`else
        mret_ack_s = 1'b0;
`endif
    end

    // FSM state, pending trap flag and latched cause.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            pend_r   <= 1'b0;
            o_mcause <= 4'd0;
        end else begin
            state_r  <= state_next_s;
            pend_r   <= pend_next_s;
            o_mcause <= mcause_next_s;
        end
    end

    // Registered storage controls and handshakes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_en        <= 1'b0;
            o_sel       <= CSR_SEL_MSCRATCH;
            o_source    <= CSR_SOURCE_CSR;
            o_trap      <= 1'b0;
            o_vec_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_csr_ack   <= 1'b0;
            o_trap_ack  <= 1'b0;
`ifdef SERV_CSR_SCHED_MRET_EN
            o_mret_ack  <= 1'b0;
`endif
        end else begin
            o_en        <= en_s;
            o_sel       <= sel_s;
            o_source    <= source_s;
            o_trap      <= trap_s;
            o_vec_valid <= vec_s;
            o_busy      <= (state_next_s != ST_IDLE);
            o_csr_ack   <= csr_ack_s;
            o_trap_ack  <= trap_ack_s;
`ifdef SERV_CSR_SCHED_MRET_EN
            o_mret_ack  <= mret_ack_s;
`endif
        end
    end

`ifndef SERV_CSR_SCHED_MRET_EN
    logic unused_s;
    assign unused_s = mret_ack_s;
`endif

endmodule

// File: tb/tb_serv_csr_sched.sv
// Bench for serv_csr_sched: directed test-plan steps followed by random traffic against a job-timeline model.
module tb_serv_csr_sched;
    import serv_params::*;

    localparam int W = 32;

    logic       clk, rst_n;
    logic       csr_req, trap_req, mret_req;
    logic [2:0] csr_sel;
    logic [1:0] csr_source;
    logic [3:0] mcause_in;
    logic       csr_ack, trap_ack, vec_valid, busy, en, trap;
    logic [2:0] sel;
    logic [1:0] source;
    logic [3:0] mcause;
`ifdef SERV_CSR_SCHED_MRET_EN
    logic       mret_ack;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: job kind (0 none, 1 csr, 2 trap, 3 mret) and offset from its first enabled cycle.
    int         mjob, moff;
    bit         mpend;
    logic [3:0] mmcause;
    logic [2:0] msel;
    logic [1:0] msrc;

    serv_csr_sched #(.W(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_csr_req    (csr_req),
        .i_csr_sel    (csr_sel),
        .i_csr_source (csr_source),
        .i_trap_req   (trap_req),
        .i_mcause     (mcause_in),
`ifdef SERV_CSR_SCHED_MRET_EN
        .i_mret_req   (mret_req),
        .o_mret_ack   (mret_ack),
`endif
        .o_csr_ack    (csr_ack),
        .o_trap_ack   (trap_ack),
        .o_vec_valid  (vec_valid),
        .o_busy       (busy),
        .o_en         (en),
        .o_sel        (sel),
        .o_source     (source),
        .o_trap       (trap),
        .o_mcause     (mcause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mjob = 0; moff = 0; mpend = 1'b0; mmcause = 4'd0; msel = 3'd0; msrc = 2'd0;
    endtask

    task automatic check_outputs();
        bit         c_act, t_save, t_vec, r_act;
        logic [2:0] e_sel;
        c_act  = (mjob == 1) && (moff < W);
        t_save = (mjob == 2) && (moff < W);
        t_vec  = (mjob == 2) && (moff >= W) && (moff < 2 * W);
        r_act  = (mjob == 3) && (moff < W);
        e_sel  = c_act ? msel : (t_save || r_act) ? CSR_SEL_MEPC : t_vec ? CSR_SEL_MTVEC : CSR_SEL_MSCRATCH;
        chk("en",       {31'd0, en},        {31'd0, c_act || t_save || t_vec || r_act});
        chk("sel",      {29'd0, sel},       {29'd0, e_sel});
        chk("source",   {30'd0, source},    {30'd0, c_act ? msrc : CSR_SOURCE_CSR});
        chk("trap",     {31'd0, trap},      {31'd0, t_save});
        chk("vec",      {31'd0, vec_valid}, {31'd0, t_vec || r_act});
        chk("csr_ack",  {31'd0, csr_ack},   {31'd0, (mjob == 1) && (moff == W)});
        chk("trap_ack", {31'd0, trap_ack},  {31'd0, (mjob == 2) && (moff == 2 * W)});
        chk("busy",     {31'd0, busy},      {31'd0, mjob != 0});
        chk("mcause",   {28'd0, mcause},    {28'd0, mmcause});
`ifdef SERV_CSR_SCHED_MRET_EN
        chk("mret_ack", {31'd0, mret_ack},  {31'd0, (mjob == 3) && (moff == W)});
`endif
    endtask

    task automatic model_advance();
        int len;
        if (!rst_n) begin
            model_reset();
        end else if (mjob == 0) begin
            if (mpend || trap_req) begin
                if (trap_req) mmcause = mcause_in;
                mpend = 1'b0; mjob = 2; moff = 0;
            end else if (mret_req) begin
                mjob = 3; moff = 0;
            end else if (csr_req) begin
                mjob = 1; moff = 0; msel = csr_sel; msrc = csr_source;
            end
        end else begin
            len = (mjob == 2) ? 2 * W : W;
            if (trap_req && (mjob != 2 || moff == len)) begin
                mpend = 1'b1; mmcause = mcause_in;
            end
            if (moff == len) mjob = 0;
            else moff++;
        end
    endtask

    task automatic tick();
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return csr_ack;
            1: return trap_ack;
            2: return trap;
`ifdef SERV_CSR_SCHED_MRET_EN
            3: return mret_ack;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int budget, output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (sig(which)) begin
                seen = 1'b1;
                at = cyc;
            end else begin
                tick();
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic rand_drive();
        if (csr_req && mjob == 1 && moff == W) begin
            csr_req = 1'b0;
        end else if (csr_req && mjob == 1 && moff < W && $urandom_range(63, 0) == 0) begin
            csr_req = 1'b0;
        end else if (!csr_req && $urandom_range(7, 0) == 0) begin
            csr_req    = 1'b1;
            csr_sel    = 3'($urandom_range(4, 0));
            csr_source = 2'($urandom_range(3, 0));
        end
        trap_req = ($urandom_range(39, 0) == 0);
        if (trap_req) mcause_in = 4'($urandom_range(15, 0));
    endtask

    initial begin
        int n, a, t, c;
        rst_n = 1'b0; csr_req = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        csr_sel = 3'd0; csr_source = 2'd0; mcause_in = 4'd0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; cyc++; end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // CSR write to mtvec with external source
        csr_req = 1'b1; csr_sel = CSR_SEL_MTVEC; csr_source = CSR_SOURCE_EXT;
        n = cyc;
        tick();
        wait_sig("csr_ack_seen", 0, 2 * W, a);
        chk("csr_ack_latency", a - n, W + 1);
        csr_req = 1'b0;
        tick();
        chk("busy_after_csr", {31'd0, busy}, 32'd0);
        repeat (2) tick();

        // Trap alone
        trap_req = 1'b1; mcause_in = 4'hB;
        n = cyc;
        tick();
        trap_req = 1'b0;
        wait_sig("trap_ack_seen", 1, 3 * W, a);
        chk("trap_ack_latency", a - n, 2 * W + 1);
        chk("trap_mcause", {28'd0, mcause}, 32'hB);
        repeat (3) tick();

        // Simultaneous CSR and trap: trap wins, CSR follows
        csr_req = 1'b1; csr_sel = CSR_SEL_MCAUSE; csr_source = CSR_SOURCE_SET;
        trap_req = 1'b1; mcause_in = 4'd5;
        tick();
        trap_req = 1'b0;
        wait_sig("simul_trap_ack", 1, 3 * W, t);
        wait_sig("simul_csr_ack", 0, 2 * W, c);
        chk("simul_csr_after_trap", c - t, W + 2);
        csr_req = 1'b0;
        repeat (3) tick();

        // Trap arriving mid CSR pass is deferred
        csr_req = 1'b1; csr_sel = CSR_SEL_MSCRATCH; csr_source = CSR_SOURCE_CLR;
        n = cyc;
        repeat (20) tick();
        trap_req = 1'b1; mcause_in = 4'd3;
        tick();
        trap_req = 1'b0;
        wait_sig("defer_csr_ack", 0, 2 * W, a);
        chk("defer_csr_latency", a - n, W + 1);
        csr_req = 1'b0;
        wait_sig("defer_trap_start", 2, 8, t);
        chk("defer_trap_gap", t - a, 2);
        chk("defer_mcause", {28'd0, mcause}, 32'd3);
        wait_sig("defer_trap_ack", 1, 3 * W, a);
        repeat (3) tick();

        // Asynchronous reset during TRAP_SAVE
        trap_req = 1'b1; mcause_in = 4'd9;
        tick();
        trap_req = 1'b0;
        repeat (15) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en",     {31'd0, en},        32'd0);
        chk("rst_trap",   {31'd0, trap},      32'd0);
        chk("rst_sel",    {29'd0, sel},       {29'd0, CSR_SEL_MSCRATCH});
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_vec",    {31'd0, vec_valid}, 32'd0);
        chk("rst_mcause", {28'd0, mcause},    32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        csr_req = 1'b1; csr_sel = CSR_SEL_MTVAL; csr_source = CSR_SOURCE_EXT;
        n = cyc;
        tick();
        wait_sig("post_rst_csr_ack", 0, 2 * W, a);
        chk("post_rst_latency", a - n, W + 1);
        csr_req = 1'b0;
        repeat (2) tick();

`ifdef SERV_CSR_SCHED_MRET_EN
        // mret streams mepc out as the new PC
        mret_req = 1'b1;
        n = cyc;
        tick();
        mret_req = 1'b0;
        wait_sig("mret_ack_seen", 3, 2 * W, a);
        chk("mret_latency", a - n, W + 1);
        repeat (2) tick();
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            tick();
        end
        csr_req = 1'b0; trap_req = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
